// File: rtl/cache_pkg.sv
// Shared types and tree-PLRU helpers for the L1 cache controller.
// The optional statistics counters are enabled with the CACHE_STATS_EN macro.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WRITEBACK = 2'd2,
        REFILL    = 2'd3
    } cache_state_t;

    // Tags are carried at a fixed maximum width; the controller zero-extends its own tags.
    localparam int TAG_MAX_W = 32;
    localparam int PLRU_W    = 3;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_MAX_W-1:0] tag;
    } line_meta_t;

    // Way pointed at by the PLRU bits of one set (always way 0 for a direct-mapped cache).
    function automatic logic [1:0] plru_victim(input int ways, input logic [PLRU_W-1:0] bits);
        logic [1:0] way;
        case (ways)
            32'sd2:  way = {1'b0, bits[0]};
            32'sd4:  way = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
            default: way = 2'd0;
        endcase
        return way;
    endfunction

    // Flip the path bits so that they point away from the way just used.
    function automatic logic [PLRU_W-1:0] plru_update(input int ways, input logic [PLRU_W-1:0] bits,
                                                      input logic [1:0] way);
        logic [PLRU_W-1:0] nxt;
        nxt = bits;
        case (ways)
            32'sd2: nxt[0] = ~way[0];
            32'sd4: begin
                nxt[0] = ~way[1];
                if (way[1]) begin
                    nxt[2] = ~way[0];
                end else begin
                    nxt[1] = ~way[0];
                end
            end
            default: nxt = 3'd0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Per-set tree-PLRU bit array: reports the victim way of the addressed set and
// records accesses to it.
module plru_tree
    import cache_pkg::*;
#(
    parameter  int SETS  = 64,
    parameter  int WAYS  = 2,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    input  logic             upd_en,
    input  logic [1:0]       upd_way,
    output logic [1:0]       victim
);

    logic [PLRU_W-1:0] bits_r [SETS];

    // Victim lookup for the addressed set
    always_comb begin
        victim = plru_victim(WAYS, bits_r[idx]);
    end

    // PLRU state: cleared asynchronously, updated on every recorded access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                bits_r[s] <= '0;
            end
        end else if (upd_en) begin
            bits_r[idx] <= plru_update(WAYS, bits_r[idx], upd_way);
        end
    end

endmodule

// File: rtl/l1_cache_ctrl.sv
// N-way set-associative write-back/write-allocate L1 cache controller with a
// line-wide refill/writeback port. Define CACHE_STATS_EN for hit/miss counters.
module l1_cache_ctrl
    import cache_pkg::*;
#(
    parameter  int ADDR_W     = 16,
    parameter  int SETS       = 64,
    parameter  int WAYS       = 2,
    parameter  int LINE_BYTES = 8,
    localparam int OFF_W      = $clog2(LINE_BYTES),
    localparam int IDX_W      = $clog2(SETS),
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W,
    localparam int LINE_W     = 8 * LINE_BYTES,
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              resp_valid,
    output logic [7:0]        resp_rdata,
    output logic              resp_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
`endif
);

    cache_state_t       state_r, next_state_s;
    logic               ready_r;
    logic [ADDR_W-1:0]  addr_r;
    logic               we_r;
    logic [7:0]         wdata_r;
    logic               hit_r;
    logic [WAY_W-1:0]   way_r;
    logic               resp_valid_r, resp_hit_r;
    logic [7:0]         resp_rdata_r;
    logic               mem_req_r, mem_we_r;
    logic [ADDR_W-1:0]  mem_addr_r;
    logic [LINE_W-1:0]  mem_wdata_r;

    logic               valid_r [WAYS][SETS];
    logic               dirty_r [WAYS][SETS];
    logic [TAG_W-1:0]   tag_r   [WAYS][SETS];
    logic [LINE_W-1:0]  data_r  [WAYS][SETS];

    logic [TAG_W-1:0]   req_tag_s, cur_tag_s;
    logic [IDX_W-1:0]   req_idx_s, cur_idx_s, lk_idx_s;
    logic [OFF_W-1:0]   req_off_s, cur_off_s;
    line_meta_t         meta_s [WAYS];
    logic [WAYS-1:0]    hit_vec_s;
    logic               hit_s;
    logic [WAY_W-1:0]   hit_way_s;
    logic               inv_found_s;
    logic [WAY_W-1:0]   inv_way_s, victim_way_s;
    logic               victim_wb_s;
    logic [1:0]         plru_victim_s;
    logic [7:0]         hit_byte_s, refill_byte_s;
    logic               refill_done_s, store_hit_s;

    assign req_tag_s = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx_s = req_addr[OFF_W +: IDX_W];
    assign req_off_s = req_addr[OFF_W-1:0];
    assign cur_tag_s = addr_r[ADDR_W-1 -: TAG_W];
    assign cur_idx_s = addr_r[OFF_W +: IDX_W];
    assign cur_off_s = addr_r[OFF_W-1:0];

    // The hit check runs on the incoming address while idle, so the response
    // register can fire during the LOOKUP cycle; victim choice uses the latched set.
    assign lk_idx_s      = (state_r == IDLE) ? req_idx_s : cur_idx_s;
    assign hit_byte_s    = data_r[hit_way_s][req_idx_s][{req_off_s, 3'b000} +: 8];
    assign refill_byte_s = mem_rdata[{cur_off_s, 3'b000} +: 8];
    assign refill_done_s = (state_r == REFILL) && mem_ack;
    assign store_hit_s   = (state_r == LOOKUP) && hit_r && we_r;

    // Metadata view of the looked-up set
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            meta_s[w].valid = valid_r[w][lk_idx_s];
            meta_s[w].dirty = dirty_r[w][lk_idx_s];
            meta_s[w].tag   = TAG_MAX_W'(tag_r[w][lk_idx_s]);
        end
    end

    // Tag compare across all ways
    always_comb begin
        hit_vec_s = '0;
        hit_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec_s[w] = meta_s[w].valid && (meta_s[w].tag == TAG_MAX_W'(req_tag_s));
            hit_way_s    = hit_way_s | (hit_vec_s[w] ? WAY_W'(w) : WAY_W'(0));
        end
        hit_s = |hit_vec_s;
    end

    // Victim selection: lowest invalid way first, PLRU otherwise
    always_comb begin
        inv_found_s = 1'b0;
        inv_way_s   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            inv_found_s = inv_found_s | ~meta_s[w].valid;
            inv_way_s   = meta_s[w].valid ? inv_way_s : WAY_W'(w);
        end
        victim_way_s = inv_found_s ? inv_way_s : WAY_W'(plru_victim_s);
        victim_wb_s  = meta_s[victim_way_s].valid & meta_s[victim_way_s].dirty;
    end

    plru_tree #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_plru (
        .clk     (clk),
        .rst     (rst),
        .idx     (cur_idx_s),
        .upd_en  ((state_r == LOOKUP) && hit_r),
        .upd_way (2'(way_r)),
        .victim  (plru_victim_s)
    );

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:      next_state_s = req_valid ? LOOKUP : IDLE;
            LOOKUP: begin
                if (hit_r) begin
                    next_state_s = IDLE;
                end else if (victim_wb_s) begin
                    next_state_s = WRITEBACK;
                end else begin
                    next_state_s = REFILL;
                end
            end
            WRITEBACK: next_state_s = mem_ack ? REFILL : WRITEBACK;
            REFILL:    next_state_s = mem_ack ? LOOKUP : REFILL;
            default:   next_state_s = IDLE;
        endcase
    end

    // Control state, latched request and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            ready_r      <= 1'b1;
            addr_r       <= '0;
            we_r         <= 1'b0;
            wdata_r      <= 8'd0;
            hit_r        <= 1'b0;
            way_r        <= '0;
            resp_valid_r <= 1'b0;
            resp_hit_r   <= 1'b0;
            resp_rdata_r <= 8'd0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
        end else begin
            state_r      <= next_state_s;
            ready_r      <= (next_state_s == IDLE);
            resp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        addr_r       <= req_addr;
                        we_r         <= req_we;
                        wdata_r      <= req_wdata;
                        hit_r        <= hit_s;
                        way_r        <= hit_way_s;
                        resp_valid_r <= hit_s;
                        resp_hit_r   <= 1'b1;
                        resp_rdata_r <= req_we ? req_wdata : hit_byte_s;
                    end
                end
                LOOKUP: begin
                    if (!hit_r) begin
                        way_r     <= victim_way_s;
                        mem_req_r <= 1'b1;
                        if (victim_wb_s) begin
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= {tag_r[victim_way_s][cur_idx_s], cur_idx_s, {OFF_W{1'b0}}};
                            mem_wdata_r <= data_r[victim_way_s][cur_idx_s];
                        end else begin
                            mem_we_r   <= 1'b0;
                            mem_addr_r <= {cur_tag_s, cur_idx_s, {OFF_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= {cur_tag_s, cur_idx_s, {OFF_W{1'b0}}};
                    end
                end
                REFILL: begin
                    // The following LOOKUP is a guaranteed hit on the refilled way
                    if (mem_ack) begin
                        mem_req_r    <= 1'b0;
                        hit_r        <= 1'b1;
                        resp_valid_r <= 1'b1;
                        resp_hit_r   <= 1'b0;
                        resp_rdata_r <= we_r ? wdata_r : refill_byte_s;
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Line valid/dirty bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_r[w][s] <= 1'b0;
                    dirty_r[w][s] <= 1'b0;
                end
            end
        end else if (refill_done_s) begin
            valid_r[way_r][cur_idx_s] <= 1'b1;
            dirty_r[way_r][cur_idx_s] <= 1'b0;
        end else if (store_hit_s) begin
            dirty_r[way_r][cur_idx_s] <= 1'b1;
        end
    end

    // Tag and data arrays, deliberately not reset
    always_ff @(posedge clk) begin
        if (refill_done_s) begin
            data_r[way_r][cur_idx_s] <= mem_rdata;
            tag_r[way_r][cur_idx_s]  <= cur_tag_s;
        end else if (store_hit_s) begin
            data_r[way_r][cur_idx_s][{cur_off_s, 3'b000} +: 8] <= wdata_r;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits_r, stat_misses_r;

    // Saturating hit/miss counters, one step per response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_hits_r   <= 32'd0;
            stat_misses_r <= 32'd0;
        end else if (resp_valid_r) begin
            if (resp_hit_r) begin
                if (stat_hits_r != 32'hFFFF_FFFF) begin
                    stat_hits_r <= stat_hits_r + 32'd1;
                end
            end else if (stat_misses_r != 32'hFFFF_FFFF) begin
                stat_misses_r <= stat_misses_r + 32'd1;
            end
        end
    end

    assign stat_hits   = stat_hits_r;
    assign stat_misses = stat_misses_r;
`endif

    assign req_ready  = ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_hit   = resp_hit_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Bench for l1_cache_ctrl: a 2-way and a 4-way instance share the stimulus bus,
// one selected at a time, each checked against a recency-based cache model.
module tb_l1_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, mem_ack = 1'b0;
    logic [15:0] req_addr = 16'd0;
    logic [7:0]  req_wdata = 8'd0;
    logic [63:0] mem_rdata = 64'd0;

    logic [1:0]  rdy_v, rv_v, rh_v, mreq_v, mwe_v;
    logic [7:0]  rdata_d [2];
    logic [15:0] maddr_d [2];
    logic [63:0] mwdata_d [2];

    logic        req_ready, resp_valid, resp_hit, mem_req, mem_we;
    logic [7:0]  resp_rdata;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;

    always #5 clk = ~clk;

    assign req_ready  = rdy_v[sel];
    assign resp_valid = rv_v[sel];
    assign resp_hit   = rh_v[sel];
    assign resp_rdata = rdata_d[sel];
    assign mem_req    = mreq_v[sel];
    assign mem_we     = mwe_v[sel];
    assign mem_addr   = maddr_d[sel];
    assign mem_wdata  = mwdata_d[sel];

`ifdef CACHE_STATS_EN
    logic [31:0] sh0, sm0, sh1, sm1;
`endif

    l1_cache_ctrl #(.ADDR_W(16), .SETS(64), .WAYS(2), .LINE_BYTES(8)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rdy_v[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv_v[0]), .resp_rdata(rdata_d[0]), .resp_hit(rh_v[0]),
        .mem_req(mreq_v[0]), .mem_we(mwe_v[0]), .mem_addr(maddr_d[0]), .mem_wdata(mwdata_d[0]),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack & ~sel)
`ifdef CACHE_STATS_EN
        , .stat_hits(sh0), .stat_misses(sm0)
`endif
    );

    l1_cache_ctrl #(.ADDR_W(16), .SETS(64), .WAYS(4), .LINE_BYTES(8)) u_dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rdy_v[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv_v[1]), .resp_rdata(rdata_d[1]), .resp_hit(rh_v[1]),
        .mem_req(mreq_v[1]), .mem_we(mwe_v[1]), .mem_addr(maddr_d[1]), .mem_wdata(mwdata_d[1]),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack & sel)
`ifdef CACHE_STATS_EN
        , .stat_hits(sh1), .stat_misses(sm1)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: per-instance cache contents, recency-tracked replacement, backing memory
    bit          m_valid [2][4][64];
    bit          m_dirty [2][4][64];
    int          m_tag   [2][4][64];
    logic [63:0] m_line  [2][4][64];
    int          m_lh    [2][64];      // half used most recently (4-way)
    int          m_lw    [2][64][2];   // way used most recently within each half
    logic [63:0] mem_img [int];

    bit          exp_hit;
    logic [7:0]  exp_rdata;
    int          ntx;
    bit          tx_we    [2];
    logic [15:0] tx_addr  [2];
    logic [63:0] tx_wdata [2];
    logic [63:0] tx_rdata [2];

    bit          last_hit;
    logic [7:0]  last_rdata;
    int          last_ntx;
    logic [15:0] obs_addr [2];
    logic [63:0] obs_wdata [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 64; s++) begin
                for (int w = 0; w < 4; w++) begin
                    m_valid[d][w][s] = 1'b0;
                    m_dirty[d][w][s] = 1'b0;
                end
                m_lh[d][s] = 1;
                m_lw[d][s][0] = 1;
                m_lw[d][s][1] = 1;
            end
        end
    endtask

    function automatic logic [63:0] mem_line(input int d, input int la);
        if (!mem_img.exists(d * 65536 + la)) mem_img[d * 65536 + la] = {$urandom, $urandom};
        return mem_img[d * 65536 + la];
    endfunction

    // Least recently used half, then least recently used way inside it
    function automatic int pick_victim(input int d, input int s);
        int h;
        if (d == 0) return 1 - m_lw[d][s][0];
        h = 1 - m_lh[d][s];
        return h * 2 + (1 - m_lw[d][s][h]);
    endfunction

    task automatic touch(input int d, input int s, input int way);
        if (d == 0) begin
            m_lw[d][s][0] = way;
        end else begin
            m_lh[d][s] = way / 2;
            m_lw[d][s][way / 2] = way % 2;
        end
    endtask

    task automatic model_access(input int d, input bit we, input logic [15:0] a, input logic [7:0] wd);
        int ways = (d == 0) ? 2 : 4;
        int s = int'(a[8:3]);
        int tg = int'(a[15:9]);
        int off = int'(a[2:0]);
        int way = -1;
        int la;
        ntx = 0;
        for (int w = 0; w < ways; w++)
            if (m_valid[d][w][s] && m_tag[d][w][s] == tg) way = w;
        exp_hit = (way >= 0);
        if (way < 0) begin
            for (int w = ways - 1; w >= 0; w--)
                if (!m_valid[d][w][s]) way = w;
            if (way < 0) way = pick_victim(d, s);
            if (m_valid[d][way][s] && m_dirty[d][way][s]) begin
                la = m_tag[d][way][s] * 512 + s * 8;
                tx_we[0] = 1'b1;
                tx_addr[0] = 16'(la);
                tx_wdata[0] = m_line[d][way][s];
                mem_img[d * 65536 + la] = m_line[d][way][s];
                ntx = 1;
            end
            la = tg * 512 + s * 8;
            tx_we[ntx] = 1'b0;
            tx_addr[ntx] = 16'(la);
            tx_rdata[ntx] = mem_line(d, la);
            m_line[d][way][s] = tx_rdata[ntx];
            m_valid[d][way][s] = 1'b1;
            m_dirty[d][way][s] = 1'b0;
            m_tag[d][way][s] = tg;
            ntx++;
        end
        if (we) begin
            m_line[d][way][s][off * 8 +: 8] = wd;
            m_dirty[d][way][s] = 1'b1;
        end
        exp_rdata = m_line[d][way][s][off * 8 +: 8];
        touch(d, s, way);
    endtask

    // One CPU request, servicing memory traffic until the response; stall=1 holds the refill ack 5 cycles
    task automatic do_req(input bit we, input logic [15:0] a, input logic [7:0] wd, input bit stall);
        int cyc;
        int tx;
        int dly;
        bit done;
        logic [15:0] held_addr;
        model_access(int'(sel), we, a, wd);
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1; tx = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            if (resp_valid) begin
                check("tx_count", 64'(tx), 64'(ntx));
                check("resp_hit", {63'd0, resp_hit}, {63'd0, exp_hit});
                check("resp_rdata", {56'd0, resp_rdata}, {56'd0, exp_rdata});
                if (exp_hit) check("hit_latency", 64'(cyc), 64'd1);
                last_hit = resp_hit; last_rdata = resp_rdata; last_ntx = tx;
                done = 1'b1;
            end else if (mem_req) begin
                if (tx >= ntx) begin
                    check("unexpected_mem_req", {63'd0, mem_req}, 64'd0);
                    done = 1'b1;
                end else begin
                    check("mem_we", {63'd0, mem_we}, {63'd0, tx_we[tx]});
                    check("mem_addr", {48'd0, mem_addr}, {48'd0, tx_addr[tx]});
                    if (tx_we[tx]) check("mem_wdata", mem_wdata, tx_wdata[tx]);
                    obs_addr[tx] = mem_addr; obs_wdata[tx] = mem_wdata;
                    held_addr = mem_addr;
                    dly = (stall && !tx_we[tx]) ? 5 : int'($urandom_range(0, 3));
                    for (int k = 0; k < dly; k++) begin
                        if (stall && k == 1) begin
                            req_valid = 1'b1; req_addr = a ^ 16'h0200;
                        end
                        @(negedge clk);
                        req_valid = 1'b0;
                        cyc++;
                        check("mem_req_held", {63'd0, mem_req}, 64'd1);
                        check("mem_addr_held", {48'd0, mem_addr}, {48'd0, held_addr});
                        check("busy_not_ready", {63'd0, req_ready}, 64'd0);
                    end
                    mem_rdata = tx_rdata[tx];
                    mem_ack = 1'b1;
                    @(negedge clk);
                    mem_ack = 1'b0;
                    mem_rdata = {$urandom, $urandom};
                    tx++; cyc++;
                end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) check("resp_timeout", 64'(cyc), 64'd0);
        @(negedge clk);
        check("resp_single_pulse", {63'd0, resp_valid}, 64'd0);
    endtask

    initial begin
        int cyc;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_ready", {63'd0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_hit", {63'd0, resp_hit}, 64'd0);
        check("rst_resp_rdata", {56'd0, resp_rdata}, 64'd0);
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_mem_we", {63'd0, mem_we}, 64'd0);
        check("rst_mem_addr", {48'd0, mem_addr}, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Cold miss then re-hit
        mem_img[32'h0120] = 64'h8877_6655_4433_2211;
        do_req(1'b0, 16'h0123, 8'h00, 1'b0);
        check("t1_miss_addr", {48'd0, obs_addr[0]}, 64'h0120);
        check("t1_miss_rdata", {56'd0, last_rdata}, 64'h44);
        check("t1_miss_hit", {63'd0, last_hit}, 64'd0);
        do_req(1'b0, 16'h0123, 8'h00, 1'b0);
        check("t1_rehit", {63'd0, last_hit}, 64'd1);
        check("t1_rehit_notx", 64'(last_ntx), 64'd0);

        // Store hit and readback
        do_req(1'b1, 16'h0125, 8'hAB, 1'b0);
        check("t2_store_hit", {63'd0, last_hit}, 64'd1);
        check("t2_store_rdata", {56'd0, last_rdata}, 64'hAB);
        do_req(1'b0, 16'h0125, 8'h00, 1'b0);
        check("t2_load_rdata", {56'd0, last_rdata}, 64'hAB);
        check("t2_load_notx", 64'(last_ntx), 64'd0);

        // Dirty eviction in set 0x24
        do_req(1'b1, 16'h0120, 8'h5A, 1'b0);
        do_req(1'b0, 16'h0320, 8'h00, 1'b0);
        do_req(1'b0, 16'h0520, 8'h00, 1'b0);
        check("t3_tx_count", 64'(last_ntx), 64'd2);
        check("t3_wb_addr", {48'd0, obs_addr[0]}, 64'h0120);
        check("t3_wb_byte0", {56'd0, obs_wdata[0][7:0]}, 64'h5A);
        check("t3_refill_addr", {48'd0, obs_addr[1]}, 64'h0520);
        check("t3_hit", {63'd0, last_hit}, 64'd0);

        // Stalled refill with a dropped request pulse
        do_req(1'b0, 16'h0723, 8'h00, 1'b1);

        // Reset in the second REFILL cycle
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0123;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (!mem_req && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_refill_started", {63'd0, mem_req}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_mem_req_drop", {63'd0, mem_req}, 64'd0);
        check("t5_resp_quiet", {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        do_req(1'b0, 16'h0123, 8'h00, 1'b0);
        check("t5_miss_after_rst", {63'd0, last_hit}, 64'd0);

        // Randomized traffic on the 2-way instance
        for (int i = 0; i < 150 && fails < 40; i++)
            do_req(1'($urandom_range(0, 1)),
                   {4'($urandom_range(0, 7)), 3'd0, 6'($urandom_range(16, 19)), 3'($urandom)},
                   8'($urandom), ($urandom_range(0, 15) == 0));

        // 4-way PLRU scenario
        sel = 1'b1;
        @(negedge clk);
        do_req(1'b0, 16'h0320, 8'h00, 1'b0);
        do_req(1'b0, 16'h0520, 8'h00, 1'b0);
        do_req(1'b0, 16'h0720, 8'h00, 1'b0);
        do_req(1'b0, 16'h0920, 8'h00, 1'b0);
        do_req(1'b0, 16'h0320, 8'h00, 1'b0);
        check("t6_touch_hit", {63'd0, last_hit}, 64'd1);
        do_req(1'b0, 16'h0B20, 8'h00, 1'b0);
        check("t6_tag5_miss", {63'd0, last_hit}, 64'd0);
        check("t6_tag5_addr", {48'd0, obs_addr[0]}, 64'h0B20);
        do_req(1'b0, 16'h0320, 8'h00, 1'b0);
        check("t6_tag1_hit", {63'd0, last_hit}, 64'd1);
        do_req(1'b0, 16'h0520, 8'h00, 1'b0);
        check("t6_tag2_hit", {63'd0, last_hit}, 64'd1);
        do_req(1'b0, 16'h0920, 8'h00, 1'b0);
        check("t6_tag4_hit", {63'd0, last_hit}, 64'd1);
        do_req(1'b0, 16'h0720, 8'h00, 1'b0);
        check("t6_tag3_evicted", {63'd0, last_hit}, 64'd0);

        // Randomized traffic on the 4-way instance
        for (int i = 0; i < 150 && fails < 40; i++)
            do_req(1'($urandom_range(0, 1)),
                   {4'($urandom_range(0, 9)), 3'd0, 6'($urandom_range(16, 19)), 3'($urandom)},
                   8'($urandom), ($urandom_range(0, 15) == 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/l1_cache_ctrl.md
Name: l1_cache_ctrl

Overview:
- Parametrised N-way set-associative, write-back, write-allocate L1 cache controller for byte-granular CPU accesses.
- Sits between one CPU load/store or fetch channel and the line-wide memory/L2 interface.
- Generalises the earlier fixed 2-way split lookup block: configurable ways, sets and line size; real refill and dirty-writeback handshakes; tree-PLRU replacement.
- The instruction and data sides each instantiate their own copy.

Parameters:
- ADDR_W, 16, address width in bits.
- SETS, 64, number of sets (power of two, ≥2).
- WAYS, 2, associativity: 1, 2 or 4.
- LINE_BYTES, 8, bytes per line (power of two, ≥2).
- Derived, not overridable: OFF_W=clog2(LINE_BYTES), IDX_W=clog2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W, LINE_W=8*LINE_BYTES.

Ports:
- clk  in  1  clock, all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1=store byte, 0=load byte.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  8  store data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  8  load data; for a store, the byte now held.
- resp_hit  out  1  1 if the original lookup hit.
- mem_req  out  1  memory transaction request, held until mem_ack.
- mem_we  out  1  1=writeback line, 0=refill line.
- mem_addr  out  ADDR_W  line-aligned address (offset bits 0).
- mem_wdata  out  LINE_W  victim line for writeback.
- mem_rdata  in  LINE_W  refill line, valid when mem_ack=1.
- mem_ack  in  1  one-cycle completion strobe.

Behaviour:
- Address split: tag=[ADDR_W-1 -: TAG_W], index=[OFF_W +: IDX_W], offset=[OFF_W-1:0]. Byte k of a line sits at bits [8k+7:8k].
- Per-line storage: valid, dirty, tag, data. Per-set storage: WAYS-1 PLRU bits (none when WAYS=1).
- Reset (rst=0, async):
  - State=IDLE; all valid, dirty and PLRU bits cleared.
  - resp_valid, resp_hit, mem_req, mem_we = 0; resp_rdata, mem_addr, mem_wdata = 0.
  - Line data is not cleared.
- req_ready=1 only in IDLE. A request is accepted on req_valid&&req_ready; addr, we and wdata are latched.
- States:
  - IDLE: on accept, go to LOOKUP.
  - LOOKUP: compare the latched tag against every way of the set; at most one way may match.
    - Hit: resp_valid=1 this cycle (latency 1 after accept); resp_hit=~miss_flag.
    - Load hit: returns the byte. Store hit: writes the byte, sets dirty, returns the written byte.
    - On hit, update PLRU to mark the way most-recent and return to IDLE.
    - Miss: set miss_flag and select a victim. The lowest-index invalid way wins; otherwise the PLRU victim.
    - Victim valid&&dirty: go to WRITEBACK. Otherwise go to REFILL.
  - WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag,index,0}, mem_wdata=victim line. All are held stable until mem_ack, then go to REFILL.
  - REFILL: mem_req=1, mem_we=0, mem_addr={req tag,index,0}, held until mem_ack.
    - On mem_ack, write mem_rdata into the victim: valid=1, dirty=0, tag=req tag. Return to LOOKUP.
    - That lookup is a guaranteed hit: resp_hit=0, miss_flag cleared.
- mem_ack outside WRITEBACK/REFILL is ignored. mem_ack in the same cycle mem_req first rises is legal.
- req_valid while req_ready=0 is ignored; the CPU must hold it.
- resp_valid is high for exactly one cycle per accepted request. Requests complete in order, one outstanding.
- Reset asserted mid-WRITEBACK/REFILL: mem_req drops immediately and the transaction is abandoned. The cache comes out empty.
- PLRU, WAYS=2: one bit pointing at the LRU way.
- PLRU, WAYS=4: 3-bit tree. Bit0 selects the half; bit1/bit2 select within the half. An access flips the path bits away from the used way.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined: adds outputs stat_hits[31:0] and stat_misses[31:0].
  - Each increments once per response (resp_hit=1 / resp_hit=0), saturating at 0xFFFFFFFF.
  - Both cleared by rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cache_pkg:
  - state enum cache_state_t {IDLE,LOOKUP,WRITEBACK,REFILL}.
  - Line-metadata struct {valid,dirty,tag}.
  - Functions for PLRU victim selection and PLRU update, parametrised on WAYS.
- One sub-module plru_tree holds the per-set PLRU bit array with async clear. Interface: set index in; access-way/update-enable in; victim way out.

Test Plan (default params: tag=[15:9], index=[8:3], offset=[2:0]):
1. Cold miss and re-hit:
   - Load 0x0123 -> mem_req rd, mem_addr=0x0120.
   - Ack with line 0x8877665544332211 -> resp_rdata=0x44, resp_hit=0.
   - Reload 0x0123 -> resp one cycle after accept, resp_hit=1, no mem_req.
2. Store hit: store 0xAB to 0x0125 -> resp_hit=1, resp_rdata=0xAB; load 0x0125 -> 0xAB, hit, no memory traffic.
3. Dirty eviction:
   - Store 0x0120=0x5A, then load 0x0320 (both in set 0x24).
   - Load 0x0520 -> WRITEBACK addr=0x0120 with byte0=0x5A, then REFILL addr=0x0520; resp_hit=0.
4. Stalled memory: hold mem_ack low 5 cycles in REFILL -> mem_req/mem_addr stable, req_ready=0, a pulsed req_valid is dropped.
5. Reset mid-REFILL: deassert rst in cycle 2 of REFILL -> mem_req=0 same cycle; after release, load 0x0123 misses again.
6. WAYS=4:
   - Fill set 0x24 with tags 1,2,3,4, then touch tag 1.
   - Miss tag 5 -> PLRU evicts tag 3's way; tag 1 still hits.
